// File: rtl/rv_src.sv
// rv_src: ready/valid burst source emitting an arithmetic word sequence with optional inter-word gaps
module rv_src #(
    parameter int WD = 4,
    parameter int LW = 8,
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [LW-1:0] cfg_len,
    input  logic [WD-1:0] cfg_seed,
    input  logic [WD-1:0] cfg_step,
    input  logic [GW-1:0] cfg_gap,
    output logic          dataout_val,
    input  logic          dataout_rdy,
    output logic [WD-1:0] dataout,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] sent_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state, state_n;
    logic [WD-1:0] step_r;
    logic [GW-1:0] gap_r, gcnt;
    logic [LW-1:0] rem;
    logic          abort_pend, hs, last;

    // next-state decode; an abort raised together with a handshake ends the burst at that handshake
    always_comb begin
        hs = dataout_val & dataout_rdy;
        last = rem == LW'(1) || abort_pend || abort;
        case (state)
            IDLE:    state_n = start ? (cfg_len == '0 ? DONE : SEND) : IDLE;
            SEND:    state_n = hs ? (last ? DONE : (gap_r == '0 ? SEND : GAP)) : SEND;
            GAP:     state_n = abort ? DONE : (gcnt == GW'(1) ? SEND : GAP);
            default: state_n = IDLE;
        endcase
    end

    // state, burst bookkeeping and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dataout_val <= 1'b0;
            dataout     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sent_cnt    <= '0;
            abort_pend  <= 1'b0;
            step_r      <= '0;
            gap_r       <= '0;
            gcnt        <= '0;
            rem         <= '0;
        end else begin
            state       <= state_n;
            dataout_val <= state_n == SEND;
            busy        <= state_n != IDLE;
            done        <= state_n == DONE;
            abort_pend  <= state_n == DONE ? 1'b0 : abort_pend | (state == SEND && abort);
            if (state == IDLE && start) begin
                step_r   <= cfg_step;
                gap_r    <= cfg_gap;
                dataout  <= cfg_seed;
                rem      <= cfg_len;
                sent_cnt <= '0;
            end
            if (hs) begin
                dataout  <= dataout + step_r;
                rem      <= rem - LW'(1);
                sent_cnt <= sent_cnt + LW'(1);
                gcnt     <= gap_r;
            end else if (state == GAP) begin
                gcnt <= gcnt - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rv_src.sv
// tb_rv_src: randomized and directed burst checks of rv_src against a burst-level expectation model
module tb_rv_src;
    localparam int WD = 4, LW = 8, GW = 4;
    logic          clk = 1'b0;
    logic          rst, start, abort, dataout_rdy, dataout_val, busy, done;
    logic [LW-1:0] cfg_len, sent_cnt;
    logic [WD-1:0] cfg_seed, cfg_step, dataout;
    logic [GW-1:0] cfg_gap;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rv_src #(.WD(WD), .LW(LW), .GW(GW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_seed(cfg_seed), .cfg_step(cfg_step), .cfg_gap(cfg_gap),
        .dataout_val(dataout_val), .dataout_rdy(dataout_rdy), .dataout(dataout),
        .busy(busy), .done(done), .sent_cnt(sent_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input int v, input int b, input int d);
        chk({tag, "_val"}, dataout_val, v);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_done"}, done, d);
    endtask

    // one burst; word k is (seed + k*step) mod 2^WD; mode 0 rdy=1, 1 toggling, 2 random
    // ab_send: word index at which abort is pulsed while stalled; ab_gap: words sent before an abort in the gap
    task automatic burst(input int seed, input int step, input int len, input int gap,
                         input int mode, input int ab_send, input int ab_gap);
        int k = 0, cyc = 0, par = 0;
        bit ab = 0, fin = 0, take;
        cfg_seed = WD'(seed); cfg_step = WD'(step); cfg_len = LW'(len); cfg_gap = GW'(gap);
        start = 1;
        @(negedge clk);
        start = 0;
        cfg_seed = WD'($urandom); cfg_step = WD'($urandom); cfg_len = LW'($urandom); cfg_gap = GW'($urandom);
        if (len == 0) begin
            outs("zero", 0, 1, 1);
            chk("zero_cnt", sent_cnt, 0);
            @(negedge clk);
            outs("zero_idle", 0, 0, 0);
            chk("zero_idle_cnt", sent_cnt, 0);
            return;
        end
        while (!fin) begin
            if (++cyc > 2000) begin
                chk("timeout", cyc, 0);
                return;
            end
            outs("send", 1, 1, 0);
            chk("data", dataout, (seed + k * step) % (1 << WD));
            abort = (k == ab_send && !ab);
            dataout_rdy = abort ? 1'b0 : mode == 0 ? 1'b1 : mode == 1 ? par[0] : ($urandom_range(0, 3) != 0);
            par ^= 1;
            ab |= abort;
            take = dataout_rdy;
            @(negedge clk);
            abort = 0;
            if (take) begin
                k++;
                chk("cnt", sent_cnt, k);
                if (k == len || ab) fin = 1;
                for (int g = 0; g < gap && !fin; g++) begin
                    outs("gap", 0, 1, 0);
                    dataout_rdy = $urandom_range(0, 1) != 0;
                    abort = (k == ab_gap && g == gap - 1);
                    fin = abort;
                    @(negedge clk);
                    abort = 0;
                end
            end
        end
        outs("end", 0, 1, 1);
        chk("end_cnt", sent_cnt, k);
        start = 1;
        abort = $urandom_range(0, 1) != 0;
        @(negedge clk);
        start = 0;
        abort = 0;
        outs("idle", 0, 0, 0);
        chk("idle_cnt", sent_cnt, k);
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; dataout_rdy = 0;
        cfg_len = 0; cfg_seed = 0; cfg_step = 0; cfg_gap = 0;
        repeat (2) @(negedge clk);
        outs("rst", 0, 0, 0);
        chk("rst_cnt", sent_cnt, 0);
        chk("rst_data", dataout, 0);
        rst = 0;
        burst(3, 5, 4, 0, 0, -1, -1);
        burst(3, 5, 4, 0, 1, -1, -1);
        burst(3, 5, 3, 2, 0, -1, -1);
        burst(1, 2, 10, 0, 0, 2, -1);
        burst(1, 2, 10, 3, 0, -1, 2);
        burst(7, 1, 0, 0, 0, -1, -1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        outs("idle_abort", 0, 0, 0);
        burst(0, 15, 3, 1, 0, -1, -1);
        cfg_seed = 5; cfg_step = 1; cfg_len = 10; cfg_gap = 0; start = 1; dataout_rdy = 0;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        outs("stall", 1, 1, 0);
        chk("stall_data", dataout, 5);
        rst = 1; start = 1; abort = 1; dataout_rdy = 1;
        @(negedge clk);
        outs("midrst", 0, 0, 0);
        chk("midrst_cnt", sent_cnt, 0);
        chk("midrst_data", dataout, 0);
        rst = 0; abort = 0; cfg_seed = 9;
        @(negedge clk);
        start = 0;
        outs("restart", 1, 1, 0);
        chk("restart_data", dataout, 9);
        chk("restart_cnt", sent_cnt, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 40; i++)
            burst($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 8), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : -1,
                  $urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
